main: RTL and testbench
=======================

MAIN -- requirements
Module: main

Interface
REQ-001 SHALL be: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL be: rst  input  1  reset; synchronous and active-high.
REQ-003 SHALL be: alu_z  output  1  ALU zero flag of the instruction currently executing; 1 when the ALU result is 32'h0.
REQ-004 SHALL be: Anode_Activate  output  8  digit enables for the 8-digit seven-segment display; active-low, one-hot.
REQ-005 SHALL be: LED_out  output  7  segment drive for the enabled digit; active-low, bit6=a down to bit0=g.
REQ-006 SHALL have parameter REFRESH_BITS, default 20, meaning the width of the display refresh counter.

Function
REQ-007 SHALL be a single-cycle RV32 core: fetch, decode, execute, memory and writeback complete in one clk period.
REQ-008 SHALL support ADD, SUB, AND, OR, XOR, SLT, SLL, SRL (R-type); ADDI (I-type); LW; SW; BEQ.
REQ-009 SHALL execute any other opcode or funct combination as a NOP: no register write, no memory write, PC+4.
REQ-010 Instruction ROM SHALL be 32 words, combinational read, indexed by PC[6:2]; PC beyond word 31 wraps to word 0.
REQ-011 Register file SHALL be 32x32 with two combinational read ports and one write port updated on the clk edge.
REQ-012 In the register file, x0 SHALL read 0 and writes to x0 SHALL be ignored.
REQ-013 Data memory SHALL be 64x32, with combinational word read, write on the clk edge, and address bits [7:2] (low bits ignored).
REQ-014 ALU arithmetic SHALL be 32-bit two's complement with no overflow trap; SLT is signed; shift amount is rs2[4:0].
REQ-015 Immediates SHALL be sign-extended per RV32I I, S and B formats.
REQ-016 Next PC SHALL be PC+imm_B when BEQ is taken (rs1==rs2, i.e. alu_z=1 on the SUB compare), otherwise PC+4.
REQ-017 A branch to itself (offset 0) SHALL hold PC and act as a halt loop.
REQ-018 Display value SHALL be the current 32-bit ALU result; digit k (0=rightmost) SHALL show nibble [4k+3:4k] in hex (0-9, A-F).
REQ-019 Free-running refresh counter REFRESH_BITS wide SHALL increment every clk; its top 3 bits select digit k, with Anode_Activate bit k low and all other bits high.
REQ-020 Segment patterns SHALL follow standard hex glyphs; e.g. 0 -> 7'b0000001, 8 -> 7'b0000000, b -> 7'b1100000.
REQ-021 Default ROM program (words 0-11, remaining words NOP 32'h00000013) SHALL be: addi x1,x0,5; addi x2,x0,3; add x3,x1,x2; sub x4,x1,x2; and x5,x1,x2; or x6,x1,x2; sw x3,0(x0); lw x7,0(x0); sub x8,x1,x1; beq x1,x1,+8; addi x9,x0,1; beq x0,x0,0.

Reset
REQ-022 While rst=1 at a clk edge, PC SHALL become 0, all registers x1-x31 SHALL become 0, and the refresh counter SHALL become 0.
REQ-023 Data memory SHALL NOT be cleared by reset.
REQ-024 A reset asserted mid-program SHALL take priority over any register, memory or PC write in the same cycle.
REQ-025 During reset, outputs SHALL reflect instruction word 0 combinationally: Anode_Activate=8'b11111110.

Structure
REQ-026 Package main_pkg SHALL hold opcode/funct constants, the ALU-op enum, the NOP constant and the default ROM contents.
REQ-027 The seven-segment multiplexer/decoder SHALL be one sub-module named main_seg7; the datapath remains in main.

Verification
REQ-028 Reset for 1 edge, then 1 edge: the ALU result is 5 (addi x1), alu_z=0, digit0 LED_out=7'b0100100, digits1-7 show 0.
REQ-029 Third instruction (add x3): the ALU result is 8, LED_out on digit0 is 7'b0000000; the fourth (sub x4) gives 2.
REQ-030 SW then LW: x7 reads 8 after the lw edge, and the lw ALU result (address) is 0, so alu_z=1.
REQ-031 sub x8,x1,x1: alu_z=1; the following beq is taken, x9 stays 0, and PC goes from 36 to 44.
REQ-032 After 16 edges, PC holds at 44 with alu_z=1; a reset pulse then returns PC to 0 and clears x1-x31.
REQ-033 With REFRESH_BITS=3, Anode_Activate SHALL step 11111110, 11111101, … 01111111 on successive edges, then wrap.

Source files
------------

// File: rtl/main_pkg.sv
// main_pkg: shared definitions for the single-cycle RV32 core "main".
//   - RV32I opcode / funct3 / funct7 constants for the supported subset
//   - ALU operation enum, ALU operand-B source enum, decoded control struct
//   - NOP encoding and the default 32-word instruction ROM image
//   - rtype_ctrl(): helper that builds the control word for an R-type op
package main_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam int ROM_WORDS  = 32;
  localparam int DMEM_WORDS = 64;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_RS2,
    SRC_IMM_I,
    SRC_IMM_S
  } src_b_e;

  typedef struct packed {
    logic    reg_we;
    logic    mem_we;
    logic    mem_to_reg;
    logic    branch;
    src_b_e  src_b;
    alu_op_e alu_op;
  } ctrl_t;

  // Anything the decoder does not recognise falls back to this: no side
  // effects, PC+4.
  localparam ctrl_t CTRL_NOP = '{
    reg_we:     1'b0,
    mem_we:     1'b0,
    mem_to_reg: 1'b0,
    branch:     1'b0,
    src_b:      SRC_IMM_I,
    alu_op:     ALU_ADD
  };

  // Word i of the ROM lives at bits [32*i +: 32].
  localparam logic [32*ROM_WORDS-1:0] DEFAULT_ROM = {
    {20{NOP_INSTR}},
    32'h00000063,  // 11: beq  x0,x0,0   (halt loop)
    32'h00100493,  // 10: addi x9,x0,1   (skipped by the branch)
    32'h00108463,  //  9: beq  x1,x1,+8
    32'h40108433,  //  8: sub  x8,x1,x1
    32'h00002383,  //  7: lw   x7,0(x0)
    32'h00302023,  //  6: sw   x3,0(x0)
    32'h0020E333,  //  5: or   x6,x1,x2
    32'h0020F2B3,  //  4: and  x5,x1,x2
    32'h40208233,  //  3: sub  x4,x1,x2
    32'h002081B3,  //  2: add  x3,x1,x2
    32'h00300113,  //  1: addi x2,x0,3
    32'h00500093   //  0: addi x1,x0,5
  };

  function automatic ctrl_t rtype_ctrl(input alu_op_e op);
    ctrl_t c;
    c        = CTRL_NOP;
    c.reg_we = 1'b1;
    c.src_b  = SRC_RS2;
    c.alu_op = op;
    return c;
  endfunction

endpackage

// File: rtl/main_seg7.sv
// main_seg7: 8-digit multiplexed seven-segment driver.
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset (clears the refresh counter)
//   i_value  : 32-bit value to display, digit k shows i_value[4k+3:4k]
//   o_anode  : digit enables, active-low, one-hot
//   o_seg    : segments a..g on bits 6..0, active-low
module main_seg7
  import main_pkg::*;
#(
  parameter int REFRESH_BITS = 20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_value,
  output logic [7:0]  o_anode,
  output logic [6:0]  o_seg
);

  localparam logic [REFRESH_BITS-1:0] ONE = REFRESH_BITS'(1);

  logic [REFRESH_BITS-1:0] r_refresh;
  logic [2:0]              w_digit;
  logic [3:0]              w_nibble;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_refresh <= '0;
    else       r_refresh <= r_refresh + ONE;
  end

  // The top three counter bits pick the digit, so each digit is held for
  // 2**(REFRESH_BITS-3) clocks.
  assign w_digit  = r_refresh[REFRESH_BITS-1 -: 3];
  assign w_nibble = i_value[{w_digit, 2'b00} +: 4];
  assign o_anode  = ~(8'b0000_0001 << w_digit);

  always_comb begin
    o_seg = 7'b1111111;
    case (w_nibble)
      4'h0: o_seg = 7'b0000001;
      4'h1: o_seg = 7'b1001111;
      4'h2: o_seg = 7'b0010010;
      4'h3: o_seg = 7'b0000110;
      4'h4: o_seg = 7'b1001100;
      4'h5: o_seg = 7'b0100100;
      4'h6: o_seg = 7'b0100000;
      4'h7: o_seg = 7'b0001111;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0000100;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b1100000;
      4'hC: o_seg = 7'b0110001;
      4'hD: o_seg = 7'b1000010;
      4'hE: o_seg = 7'b0110000;
      4'hF: o_seg = 7'b0111000;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/main.sv
// main: single-cycle RV32 subset core (ADD SUB AND OR XOR SLT SLL SRL ADDI
// LW SW BEQ) whose ALU result is shown on an 8-digit seven-segment display.
//   clk            : system clock, all state updates on the rising edge
//   rst            : synchronous active-high reset (PC, x1-x31, refresh ctr)
//   alu_z          : 1 when the current instruction's ALU result is zero
//   Anode_Activate : digit enables, active-low one-hot
//   LED_out        : segments a..g on bits 6..0, active-low
// ROM_IMAGE holds the 32-word program; word i sits at bits [32*i +: 32].
module main
  import main_pkg::*;
#(
  parameter int                        REFRESH_BITS = 20,
  parameter logic [32*ROM_WORDS-1:0]   ROM_IMAGE    = DEFAULT_ROM
) (
  input  logic       clk,
  input  logic       rst,
  output logic       alu_z,
  output logic [7:0] Anode_Activate,
  output logic [6:0] LED_out
);

  logic [31:0] r_pc;
  logic [31:0] r_regs [32];
  logic [31:0] r_dmem [DMEM_WORDS];

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_result;
  logic [31:0] w_mem_rdata;
  logic [31:0] w_wb_data;
  logic [31:0] w_pc_next;
  ctrl_t       w_ctrl;

  // Fetch: PC[6:2] indexes the ROM, so PCs past word 31 wrap to word 0.
  assign w_instr = ROM_IMAGE[{r_pc[6:2], 5'b00000} +: 32];

  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_funct3 = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_funct7 = w_instr[31:25];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                    w_instr[30:25], w_instr[11:8], 1'b0};

  always_comb begin
    w_ctrl = CTRL_NOP;
    case (w_opcode)
      OP_RTYPE: begin
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            F3_ADD_SUB: w_ctrl = rtype_ctrl(ALU_ADD);
            F3_SLL:     w_ctrl = rtype_ctrl(ALU_SLL);
            F3_SLT:     w_ctrl = rtype_ctrl(ALU_SLT);
            F3_XOR:     w_ctrl = rtype_ctrl(ALU_XOR);
            F3_SRL:     w_ctrl = rtype_ctrl(ALU_SRL);
            F3_OR:      w_ctrl = rtype_ctrl(ALU_OR);
            F3_AND:     w_ctrl = rtype_ctrl(ALU_AND);
            default:    w_ctrl = CTRL_NOP;
          endcase
        end else if (w_funct7 == F7_ALT && w_funct3 == F3_ADD_SUB) begin
          w_ctrl = rtype_ctrl(ALU_SUB);
        end
      end
      OP_IMM: begin
        if (w_funct3 == F3_ADDI) w_ctrl.reg_we = 1'b1;
      end
      OP_LOAD: begin
        if (w_funct3 == F3_LW) begin
          w_ctrl.reg_we     = 1'b1;
          w_ctrl.mem_to_reg = 1'b1;
        end
      end
      OP_STORE: begin
        if (w_funct3 == F3_SW) begin
          w_ctrl.mem_we = 1'b1;
          w_ctrl.src_b  = SRC_IMM_S;
        end
      end
      OP_BRANCH: begin
        // BEQ compares by subtracting; the zero flag decides the branch.
        if (w_funct3 == F3_BEQ) begin
          w_ctrl.branch = 1'b1;
          w_ctrl.src_b  = SRC_RS2;
          w_ctrl.alu_op = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

  always_comb begin
    w_alu_b = w_imm_i;
    case (w_ctrl.src_b)
      SRC_RS2:   w_alu_b = w_rs2_data;
      SRC_IMM_S: w_alu_b = w_imm_s;
      default:   w_alu_b = w_imm_i;
    endcase
  end

  always_comb begin
    w_alu_result = w_rs1_data + w_alu_b;
    case (w_ctrl.alu_op)
      ALU_ADD: w_alu_result = w_rs1_data + w_alu_b;
      ALU_SUB: w_alu_result = w_rs1_data - w_alu_b;
      ALU_AND: w_alu_result = w_rs1_data & w_alu_b;
      ALU_OR:  w_alu_result = w_rs1_data | w_alu_b;
      ALU_XOR: w_alu_result = w_rs1_data ^ w_alu_b;
      ALU_SLT: w_alu_result = {31'd0, $signed(w_rs1_data) < $signed(w_alu_b)};
      ALU_SLL: w_alu_result = w_rs1_data << w_alu_b[4:0];
      ALU_SRL: w_alu_result = w_rs1_data >> w_alu_b[4:0];
      default: w_alu_result = w_rs1_data + w_alu_b;
    endcase
  end

  assign alu_z = (w_alu_result == 32'd0);

  // Word-addressed data memory: byte-offset bits [1:0] are ignored.
  assign w_mem_rdata = r_dmem[w_alu_result[7:2]];
  assign w_wb_data   = w_ctrl.mem_to_reg ? w_mem_rdata : w_alu_result;

  // An offset-0 taken BEQ leaves PC unchanged, which is the halt loop.
  assign w_pc_next = (w_ctrl.branch && alu_z) ? (r_pc + w_imm_b)
                                              : (r_pc + 32'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= 32'd0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
      r_pc <= w_pc_next;
      if (w_ctrl.reg_we && (w_rd != 5'd0)) r_regs[w_rd] <= w_wb_data;
    end
  end

  // Contents survive reset; reset only blocks a store in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && w_ctrl.mem_we) r_dmem[w_alu_result[7:2]] <= w_rs2_data;
  end

  main_seg7 #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_seg7 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_value (w_alu_result),
    .o_anode (Anode_Activate),
    .o_seg   (LED_out)
  );

endmodule

// File: tb/tb_main.sv
// tb_main: two cores run side by side against an instruction-level model.
//   u_dut0: default ROM program, REFRESH_BITS=3 (one digit per clock)
//   u_dut1: bench-written program exercising SLT/SLL/SRL/XOR, negative
//           immediates, a non-taken BEQ, an unsupported funct7, x0 writes
//           and a backward loop; REFRESH_BITS=5 (four clocks per digit)
// Random reset pulses are applied throughout the second phase.
module tb_main;

  localparam logic [1023:0] PROG2 = {
    {16{32'h00000013}},
    32'hFE000AE3,  // 15: beq  x0,x0,-12
    32'h000005B3,  // 14: add  x11,x0,x0
    32'h00150513,  // 13: addi x10,x10,1
    32'h00500013,  // 12: addi x0,x0,5
    32'h00100493,  // 11: addi x9,x0,1   (skipped)
    32'h00138463,  // 10: beq  x7,x1,+8  (taken)
    32'h00208463,  //  9: beq  x1,x2,+8  (not taken)
    32'h02208433,  //  8: funct7=1 R-type -> NOP
    32'h0FC02383,  //  7: lw   x7,252(x0)
    32'hFE112E23,  //  6: sw   x1,-4(x2)
    32'h0020C333,  //  5: xor  x6,x1,x2
    32'h0020D2B3,  //  4: srl  x5,x1,x2
    32'h00209233,  //  3: sll  x4,x1,x2
    32'h0020A1B3,  //  2: slt  x3,x1,x2
    32'h00300113,  //  1: addi x2,x0,3
    32'hFF900093   //  0: addi x1,x0,-7
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  z;
  logic [7:0]  an  [2];
  logic [6:0]  led [2];
  logic [31:0] w_pc  [2];
  logic [31:0] w_res [2];

  main #(.REFRESH_BITS(3)) u_dut0 (
    .clk(clk), .rst(rst), .alu_z(z[0]), .Anode_Activate(an[0]), .LED_out(led[0])
  );
  main #(.REFRESH_BITS(5), .ROM_IMAGE(PROG2)) u_dut1 (
    .clk(clk), .rst(rst), .alu_z(z[1]), .Anode_Activate(an[1]), .LED_out(led[1])
  );

  assign w_pc[0]  = u_dut0.r_pc;
  assign w_pc[1]  = u_dut1.r_pc;
  assign w_res[0] = u_dut0.w_alu_result;
  assign w_res[1] = u_dut1.w_alu_result;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rom  [2][32];
  logic [31:0] m_regs [2][32];
  logic [31:0] m_dmem [2][64];
  logic [31:0] m_pc   [2];
  int unsigned m_ref  [2];
  int          m_rb   [2] = '{3, 5};
  bit          m_valid = 1'b0;

  typedef struct {
    logic [31:0] res;
    bit          known;
    logic [31:0] npc;
    bit          wr_reg;
    int          rd;
    logic [31:0] wdata;
    bit          wr_mem;
    int          maddr;
    logic [31:0] mdata;
  } step_t;

  function automatic logic [31:0] rreg(int k, int r);
    return (r == 0) ? 32'd0 : m_regs[k][r];
  endfunction

  // Architectural effect of the instruction at the model's PC.
  function automatic step_t model_exec(int k);
    step_t s;
    logic [31:0] ins, a, b, imm_i, imm_s, imm_b;
    bit is_load;
    ins   = m_rom[k][(m_pc[k] / 4) % 32];
    a     = rreg(k, int'(ins[19:15]));
    b     = rreg(k, int'(ins[24:20]));
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    s.res = 32'd0; s.known = 0; s.npc = m_pc[k] + 4; s.wr_reg = 0;
    s.rd = int'(ins[11:7]); s.wdata = 32'd0; s.wr_mem = 0; s.maddr = 0; s.mdata = 32'd0;
    is_load = 0;
    case (ins[6:0])
      7'h33: begin
        if (ins[31:25] == 7'h00) begin
          s.known = 1;
          case (int'(ins[14:12]))
            0: s.res = a + b;
            1: s.res = a << b[4:0];
            2: s.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4: s.res = a ^ b;
            5: s.res = a >> b[4:0];
            6: s.res = a | b;
            7: s.res = a & b;
            default: s.known = 0;
          endcase
        end else if (ins[31:25] == 7'h20 && ins[14:12] == 3'd0) begin
          s.known = 1;
          s.res = a - b;
        end
        s.wr_reg = s.known;
      end
      7'h13: if (ins[14:12] == 3'd0) begin s.known = 1; s.wr_reg = 1; s.res = a + imm_i; end
      7'h03: if (ins[14:12] == 3'd2) begin
        s.known = 1; s.wr_reg = 1; is_load = 1;
        s.res = a + imm_i;
        s.wdata = m_dmem[k][int'((s.res >> 2) % 64)];
      end
      7'h23: if (ins[14:12] == 3'd2) begin
        s.known = 1; s.wr_mem = 1;
        s.res = a + imm_s;
        s.maddr = int'((s.res >> 2) % 64);
        s.mdata = b;
      end
      7'h63: if (ins[14:12] == 3'd0) begin
        s.known = 1;
        s.res = a - b;
        if (a == b) s.npc = m_pc[k] + imm_b;
      end
      default: ;
    endcase
    if (!is_load) s.wdata = s.res;
    if (s.rd == 0) s.wr_reg = 0;
    return s;
  endfunction

  // Lit segments per hex glyph; every listed segment is driven low.
  function automatic logic [6:0] glyph(logic [3:0] n);
    string s;
    logic [6:0] g;
    case (n)
      4'h0: s = "abcdef";  4'h1: s = "bc";      4'h2: s = "abdeg";   4'h3: s = "abcdg";
      4'h4: s = "bcfg";    4'h5: s = "acdfg";   4'h6: s = "acdefg";  4'h7: s = "abc";
      4'h8: s = "abcdefg"; 4'h9: s = "abcdfg";  4'hA: s = "abcefg";  4'hB: s = "cdefg";
      4'hC: s = "adef";    4'hD: s = "bcdeg";   4'hE: s = "adefg";   default: s = "aefg";
    endcase
    g = 7'h7F;
    for (int i = 0; i < s.len(); i++) g[6 - (int'(s[i]) - 97)] = 1'b0;
    return g;
  endfunction

  function automatic int cur_digit(int k);
    return int'((m_ref[k] >> (m_rb[k] - 3)) % 8);
  endfunction

  // Model advances on every rising edge.
  initial begin
    logic [31:0] prog0 [12] = '{
      32'h00500093, 32'h00300113, 32'h002081B3, 32'h40208233,
      32'h0020F2B3, 32'h0020E333, 32'h00302023, 32'h00002383,
      32'h40108433, 32'h00108463, 32'h00100493, 32'h00000063 };
    for (int i = 0; i < 32; i++) begin
      m_rom[0][i] = (i < 12) ? prog0[i] : 32'h00000013;
      m_rom[1][i] = PROG2[32*i +: 32];
    end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) m_dmem[k][i] = 32'd0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
          m_pc[k] = 32'd0;
          m_ref[k] = 0;
          for (int r = 0; r < 32; r++) m_regs[k][r] = 32'd0;
        end
      end else if (m_valid) begin
        for (int k = 0; k < 2; k++) begin
          step_t st;
          st = model_exec(k);
          if (st.wr_reg) m_regs[k][st.rd] = st.wdata;
          if (st.wr_mem) m_dmem[k][st.maddr] = st.mdata;
          m_pc[k] = st.npc;
          m_ref[k] = (m_ref[k] + 1) % (1 << m_rb[k]);
        end
      end
    end
  end

  // Compare process: every falling edge once the model is defined.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        for (int k = 0; k < 2; k++) begin
          step_t st;
          st = model_exec(k);
          check($sformatf("pc%0d", k), w_pc[k], m_pc[k]);
          check($sformatf("anode%0d", k), {24'd0, an[k]}, {24'd0, ~(8'h01 << cur_digit(k))});
          if (st.known) begin
            check($sformatf("alu%0d", k), w_res[k], st.res);
            check($sformatf("z%0d", k), {31'd0, z[k]}, {31'd0, st.res == 32'd0});
            check($sformatf("led%0d", k), {25'd0, led[k]},
                  {25'd0, glyph(st.res[4*cur_digit(k) +: 4])});
          end
        end
      end
    end
  end

  // ---------------- driver: directed pins, then random resets ----------------
  initial begin
    int nz;
    rst = 1'b1;
    @(negedge clk);
    check("rst_anode", {24'd0, an[0]}, 32'h000000FE);
    check("c0_alu", w_res[0], 32'd5);
    check("c0_z", {31'd0, z[0]}, 32'd0);
    check("c0_led", {25'd0, led[0]}, {25'd0, 7'b0100100});
    rst = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check("step_anode", {24'd0, an[0]}, {24'd0, ~(8'h01 << c)});
      check("upper_digit", {25'd0, led[0]}, {25'd0, 7'b0000001});
      if (c == 2) begin
        check("add_alu", w_res[0], 32'd8);
        check("slt_alu", w_res[1], 32'd1);
      end
      if (c == 3) begin
        check("sub_alu", w_res[0], 32'd2);
        check("sll_alu", w_res[1], 32'hFFFFFFC8);
      end
      if (c == 4) check("srl_alu", w_res[1], 32'h1FFFFFFF);
      if (c == 7) begin
        check("lw_addr", w_res[0], 32'd0);
        check("lw_z", {31'd0, z[0]}, 32'd1);
      end
    end
    @(negedge clk);
    check("anode_wrap", {24'd0, an[0]}, 32'h000000FE);
    check("x7_loaded", u_dut0.r_regs[7], 32'd8);
    check("x7_neg_loaded", u_dut1.r_regs[7], 32'hFFFFFFF9);
    check("sub_self_z", {31'd0, z[0]}, 32'd1);
    @(negedge clk);
    check("beq_pc", w_pc[0], 32'd36);
    @(negedge clk);
    check("taken_pc", w_pc[0], 32'd44);
    repeat (5) @(negedge clk);
    check("halt_pc", w_pc[0], 32'd44);
    check("halt_z", {31'd0, z[0]}, 32'd1);
    check("x9_skipped", u_dut0.r_regs[9], 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_pc", w_pc[0], 32'd0);
    nz = 0;
    for (int r = 1; r < 32; r++) if (u_dut0.r_regs[r] != 32'd0) nz++;
    check("regs_cleared", nz, 32'd0);
    check("dmem_kept", u_dut0.r_dmem[0], 32'd8);

    for (int seg = 0; seg < 14; seg++) begin
      rst = 1'b0;
      repeat ($urandom_range(30, 3)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(2, 1)) @(negedge clk);
    end
    rst = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
